alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer.sv | 190 +++++++++++++++++++
 tb/tb_alu_issuer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
`timescale 1ns/1ps
// alu_issuer: accepts one ALU request at a time, drives the registered ALU
// command and operands, waits for multi-cycle completion with a timeout, and
// presents a held response until the consumer takes it.
module alu_issuer #(
  // Maximum number of WAIT_FIN cycles before a multi-cycle op is abandoned (2..255)
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  // Request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_sh,
  input  logic [3:0]  req_pos,
  // ALU command / operand drive
  output logic [3:0]  alu_control,
  output logic [15:0] alu_nr1,
  output logic [15:0] alu_nr2,
  output logic        alu_sh,
  output logic [3:0]  alu_pos,
  output logic        alu_bgn,
  // ALU completion and result
  input  logic        alu_fin,
  input  logic [31:0] alu_outbus,
  input  logic        alu_carry,
  input  logic        alu_borrow,
  // Response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_flags,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_FIN,
    SETTLE,
    RESP
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      state_q;
  logic        req_ready_q;
  logic [3:0]  op_q;
  logic [3:0]  alu_control_q;
  logic [15:0] alu_nr1_q;
  logic [15:0] alu_nr2_q;
  logic        alu_sh_q;
  logic [3:0]  alu_pos_q;
  logic        alu_bgn_q;
  logic [7:0]  wait_cnt_q;
  logic [7:0]  wait_cnt_d;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_flags_q;
  logic        rsp_err_q;
  logic [15:0] op_count_q;
  logic [15:0] op_count_d;

  // Opcodes 0..6 are implemented by the ALU; everything above is rejected.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'd6;
  endfunction

  // Divide and multiply take several ALU cycles and need the start strobe.
  function automatic logic op_multi(input logic [3:0] op);
    return op <= 4'd1;
  endfunction

  // Incremented values of the timeout counter and the response counter
  always_comb begin
    wait_cnt_d = wait_cnt_q + 8'd1;
    op_count_d = op_count_q + 16'd1;
  end

  // Issue FSM; every output comes straight from a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      op_q          <= 4'd0;
      alu_control_q <= 4'd0;
      alu_nr1_q     <= 16'd0;
      alu_nr2_q     <= 16'd0;
      alu_sh_q      <= 1'b0;
      alu_pos_q     <= 4'd0;
      alu_bgn_q     <= 1'b0;
      wait_cnt_q    <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_flags_q   <= 2'b00;
      rsp_err_q     <= 1'b0;
      op_count_q    <= 16'd0;
    end else begin
      // The start strobe is a one-cycle pulse unless re-armed below.
      alu_bgn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= req_op;
            state_q     <= ISSUE;
            // Drive the ALU at acceptance so the command is valid for the
            // whole ISSUE cycle; illegal ops leave the previous drive alone.
            if (op_legal(req_op)) begin
              alu_control_q <= req_op;
              alu_nr1_q     <= req_a;
              alu_nr2_q     <= req_b;
              alu_sh_q      <= req_sh;
              alu_pos_q     <= req_pos;
              alu_bgn_q     <= op_multi(req_op);
            end
          end
        end
        ISSUE: begin
          // Illegal ops pass through here without ALU activity so their
          // error response appears one edge after acceptance.
          if (!op_legal(op_q)) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= 32'd0;
            rsp_flags_q <= 2'b00;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else if (op_multi(op_q)) begin
            wait_cnt_q <= 8'd0;
            state_q    <= WAIT_FIN;
          end else begin
            state_q <= SETTLE;
          end
        end
        WAIT_FIN: begin
          if (alu_fin) begin
            state_q <= SETTLE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d == TO_LIMIT) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 32'd0;
              rsp_flags_q <= 2'b00;
              rsp_err_q   <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        SETTLE: begin
          // The ALU result register has had a cycle to load; take it as is.
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= alu_outbus;
          rsp_flags_q <= {alu_borrow, alu_carry};
          rsp_err_q   <= 1'b0;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign alu_control = alu_control_q;
  assign alu_nr1     = alu_nr1_q;
  assign alu_nr2     = alu_nr2_q;
  assign alu_sh      = alu_sh_q;
  assign alu_pos     = alu_pos_q;
  assign alu_bgn     = alu_bgn_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_err     = rsp_err_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issuer.sv
`timescale 1ns/1ps
// tb_alu_issuer: directed and random requests against alu_issuer with a
// behavioural ALU in the loop and an operation-level expectation model.
module tb_alu_issuer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_sh;
  logic [3:0]  req_pos;
  logic [3:0]  alu_control;
  logic [15:0] alu_nr1;
  logic [15:0] alu_nr2;
  logic        alu_sh;
  logic [3:0]  alu_pos;
  logic        alu_bgn;
  logic        alu_fin;
  logic [31:0] alu_outbus;
  logic        alu_carry;
  logic        alu_borrow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] op_count;

  int vectors = 0;
  int miscompares = 0;

  // Expected ALU drive and response count
  logic [3:0]  m_ctrl;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        m_sh;
  logic [3:0]  m_pos;
  logic [15:0] m_count;

  // ALU environment controls
  int   fin_dly = 0;
  int   fin_cd = 0;
  logic fin_q = 1'b0;
  logic stray_fin = 1'b0;

  alu_issuer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_sh(req_sh), .req_pos(req_pos),
    .alu_control(alu_control), .alu_nr1(alu_nr1), .alu_nr2(alu_nr2),
    .alu_sh(alu_sh), .alu_pos(alu_pos), .alu_bgn(alu_bgn),
    .alu_fin(alu_fin), .alu_outbus(alu_outbus), .alu_carry(alu_carry),
    .alu_borrow(alu_borrow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ALU behaviour: returns {borrow, carry, result}
  function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic sh,
                                          input logic [3:0] pos);
    logic [15:0] ae;
    logic [16:0] s;
    ae = sh ? (a << pos) : a;
    case (op)
      4'd0: begin
        if (b == 16'd0) return {2'b00, 32'hFFFF_FFFF};
        return {2'b00, ae % b, ae / b};
      end
      4'd1: return {2'b00, 32'(ae) * 32'(b)};
      4'd2: begin
        s = {1'b0, ae} - {1'b0, b};
        return {s[16], 1'b0, 16'h0000, s[15:0]};
      end
      4'd3: begin
        s = {1'b0, ae} + {1'b0, b};
        return {1'b0, s[16], 16'h0000, s[15:0]};
      end
      4'd4: return {18'd0, ae | b};
      4'd5: return {18'd0, ae & b};
      4'd6: return {18'd0, ae ^ b};
      default: return 34'd0;
    endcase
  endfunction

  assign alu_fin = fin_q | stray_fin;

  // Registered ALU model with a programmable completion delay after alu_bgn
  always @(posedge clk) begin
    {alu_borrow, alu_carry, alu_outbus} <= alu_ref(alu_control, alu_nr1, alu_nr2, alu_sh, alu_pos);
    if (alu_bgn && fin_dly > 0) begin
      fin_cd <= fin_dly;
      fin_q  <= 1'b0;
    end else if (fin_cd > 0) begin
      fin_cd <= fin_cd - 1;
      fin_q  <= (fin_cd == 1);
    end else begin
      fin_q <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    m_ctrl = 4'd0; m_a = 16'd0; m_b = 16'd0; m_sh = 1'b0; m_pos = 4'd0; m_count = 16'd0;
  endtask

  // One complete request/response; fdly=0 means the ALU never finishes.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic sh, input logic [3:0] pos, input int fdly, input int hold);
    logic [33:0] r;
    logic [31:0] e_data;
    logic [1:0]  e_flags;
    logic        e_err;
    int          e_lat;
    int          edges;
    int          bgn_n;
    int          fin_edge;
    logic        legal;
    legal = (op <= 4'd6);
    fin_dly = fdly;
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_op = op; req_a = a; req_b = b; req_sh = sh; req_pos = pos; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 0; bgn_n = 0; fin_edge = -1;
    while (rsp_valid !== 1'b1 && edges < 300) begin
      if (alu_bgn === 1'b1) bgn_n++;
      if (alu_fin === 1'b1 && fin_edge < 0) fin_edge = edges + 1;
      @(posedge clk); #1;
      edges++;
    end
    if (!legal) begin
      e_data = 32'd0; e_flags = 2'b00; e_err = 1'b1; e_lat = 1;
    end else begin
      r = alu_ref(op, a, b, sh, pos);
      m_ctrl = op; m_a = a; m_b = b; m_sh = sh; m_pos = pos;
      if (op <= 4'd1 && fin_edge < 0) begin
        e_data = 32'd0; e_flags = 2'b00; e_err = 1'b1; e_lat = 1 + TIMEOUT;
      end else begin
        e_data = r[31:0]; e_flags = r[33:32]; e_err = 1'b0;
        e_lat = (op <= 4'd1) ? fin_edge + 1 : 2;
      end
    end
    chk("latency", 32'(edges), 32'(e_lat));
    chk("rsp_data", rsp_data, e_data);
    chk("rsp_flags", 32'(rsp_flags), 32'(e_flags));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("bgn_cycles", 32'(bgn_n), (legal && op <= 4'd1) ? 32'd1 : 32'd0);
    chk("alu_control", 32'(alu_control), 32'(m_ctrl));
    chk("alu_nr1", 32'(alu_nr1), 32'(m_a));
    chk("alu_nr2", 32'(alu_nr2), 32'(m_b));
    chk("alu_sh_pos", 32'({alu_sh, alu_pos}), 32'({m_sh, m_pos}));
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_op = 4'd5; req_a = ~a; req_b = ~b; req_valid = 1'b1;
      end
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, e_data);
      chk("hold_flags", 32'(rsp_flags), 32'(e_flags));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    m_count = m_count + 16'd1;
    chk("valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(m_count));
    chk("ready_after_hs", 32'(req_ready), 32'd1);
    chk("ctrl_after_hs", 32'(alu_control), 32'(m_ctrl));
    chk("nr1_after_hs", 32'(alu_nr1), 32'(m_a));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_ctrl"}, 32'(alu_control), 32'd0);
    chk({tag, "_nr1"}, 32'(alu_nr1), 32'd0);
    chk({tag, "_nr2"}, 32'(alu_nr2), 32'd0);
    chk({tag, "_shpos"}, 32'({alu_sh, alu_pos}), 32'd0);
    chk({tag, "_bgn"}, 32'(alu_bgn), 32'd0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp"}, rsp_data, 32'd0);
    chk({tag, "_flags_err"}, 32'({rsp_flags, rsp_err}), 32'd0);
    chk({tag, "_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 16'd0; req_b = 16'd0;
    req_sh = 1'b0; req_pos = 4'd0; rsp_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);

    // Directed operations
    run_op(4'd6, 16'h00FF, 16'h0F0F, 1'b0, 4'd0, 0, 0);
    run_op(4'd3, 16'hFFFF, 16'h0001, 1'b0, 4'd0, 0, 0);
    run_op(4'd2, 16'h0000, 16'h0001, 1'b0, 4'd0, 0, 1);
    run_op(4'd1, 16'h0003, 16'h0005, 1'b0, 4'd0, 17, 0);
    run_op(4'd0, 16'd1000, 16'd7, 1'b0, 4'd0, 0, 0);
    run_op(4'd9, 16'hABCD, 16'h1234, 1'b1, 4'd3, 0, 0);
    run_op(4'd5, 16'hF0F0, 16'h3C3C, 1'b0, 4'd0, 0, 5);
    run_op(4'd3, 16'h0123, 16'h0001, 1'b1, 4'd4, 0, 2);
    run_op(4'd0, 16'd500, 16'd9, 1'b0, 4'd0, 6, 0);

    // ALU completion outside WAIT_FIN has no effect
    stray_fin = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray_fin_valid", 32'(rsp_valid), 32'd0);
      chk("stray_fin_ready", 32'(req_ready), 32'd1);
    end
    stray_fin = 1'b0;

    // Reset while waiting for the ALU abandons the operation
    fin_dly = 0;
    req_op = 4'd0; req_a = 16'd50; req_b = 16'd3; req_sh = 1'b0; req_pos = 4'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("wait_fin_no_rsp", 32'(rsp_valid), 32'd0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mid_wait_rst");
    @(negedge clk); rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    chk("ready_after_mid_rst", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
    end

    // Reset during the start strobe drops it at once
    fin_dly = 5;
    req_op = 4'd1; req_a = 16'd7; req_b = 16'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bgn_in_issue", 32'(alu_bgn), 32'd1);
    #2 rst = 1'b1;
    #1 chk("bgn_forced_low", 32'(alu_bgn), 32'd0);
    chk("ctrl_reset_in_issue", 32'(alu_control), 32'd0);
    @(negedge clk); rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
    run_op(4'd1, 16'h0003, 16'h0005, 1'b0, 4'd0, 9, 0);
    run_op(4'd4, 16'h1200, 16'h0034, 1'b0, 4'd0, 0, 0);

    // Random traffic
    for (int k = 0; k < 30; k++) begin
      logic [3:0] rop;
      int         fd;
      rop = 4'($urandom_range(0, 8));
      fd  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      run_op(rop, 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), fd,
             int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
